super_sys_drain: RTL and testbench
==================================

# super_sys_drain

Output-side collector for the super systolic array. It receives the column-staggered partial sums leaving the array on `of_data`/`valid`/`accum_start`, de-skews them into whole rows, and accumulates successive K-tiles into a row buffer. After the last tile, it drains finished rows one per handshake to the downstream writeback path. It sits directly behind the array, between its `of_data` port and the output memory writer.

## Interface
- `COLS`, 16 (SUPER_SYS_COLS): array columns, one lane each.
- `P_BITWIDTH`, 24: width of one incoming partial sum.
- `ACC_W`, 32: accumulator and output element width; must be at least `P_BITWIDTH`.
- `DEPTH`, 16: maximum rows per tile held in the buffer.
- `clk`  input  1  clock; all logic is on the rising edge.
- `rst`  input  1  synchronous, active-low reset.
- `of_data`  input  COLS×P_BITWIDTH  staggered partial sums from the array, signed.
- `valid`  input  1  column-0 element of a row is present this cycle.
- `accum_start`  input  1  one-cycle pulse one cycle before the first `valid` of a tile.
- `tile_first`  input  1  sampled with `accum_start`: this tile overwrites instead of adding.
- `tile_last`  input  1  sampled with `accum_start`: drain after this tile.
- `in_ready`  output  1  high when not in DRAIN.
- `out_data`  output  COLS×ACC_W  one finished row.
- `out_valid`  output  1  `out_data` holds a valid row.
- `out_ready`  input  1  downstream accepts the row.
- `out_last`  output  1  the current output row is the final row.
- `err`  output  1  sticky error: overflow of row count, or input arriving during DRAIN.

## Operation
- Input contract: element c of a row appears on `of_data[c]` exactly c cycles after that row's `valid` cycle.
- De-skew:
  - Lane c passes through COLS-1-c registers. Lane COLS-1 has none.
  - `valid` and `accum_start` pass through COLS-1 registers.
  - Result is the aligned signals `row_v`, `row_start`, `row`.
- States:
  - IDLE → ACCUM on `row_start`.
  - ACCUM → DRAIN on the falling edge of `row_v` when the latched `last` is 1.
  - ACCUM → IDLE on the falling edge of `row_v` when `last` is 0; the buffer is retained.
  - DRAIN → IDLE after the handshake on `out_last`.
- On `row_start`:
  - `tile_first`/`tile_last` (captured at `accum_start` and piped with it) latch into `first`/`last`.
  - Row counter `wr_row` clears to 0.
- Each `row_v` cycle in ACCUM:
  - `buf[wr_row][c]` is written with `first ? sext(row[c]) : buf[wr_row][c] + sext(row[c])`.
  - `wr_row` then increments, and `n_rows` is set to max(`n_rows`, `wr_row`+1).
  - If `wr_row` == DEPTH, the row is dropped and `err` is set.
- Arithmetic: sign-extend from P_BITWIDTH to ACC_W, then perform an ACC_W-bit two's-complement add. Overflow handling is described under Configuration.
- DRAIN:
  - `rd_row` runs 0..`n_rows`-1.
  - `out_data` = `buf[rd_row]`, `out_valid` = 1, `out_last` = (`rd_row` == `n_rows`-1).
  - A handshake (`out_valid` && `out_ready`) advances `rd_row`.
  - `out_data` and `out_last` hold stable while `out_valid` is high and `out_ready` is low.
  - When the drain completes, `n_rows` clears to 0.
- `valid` seen at the input while in DRAIN sets `err`, and the data is discarded.
- A `row_start` while already in ACCUM starts a new tile; the counter restarts with no error.
- `first` tile with `n_rows` == 0 followed by `last` draining 0 rows is impossible: entering DRAIN requires at least one `row_v`.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_data`=0, `in_ready`=1, `err`=0. State = IDLE; all counters, pipelines and the buffer are cleared.
- Reset asserted mid-operation aborts any state with no output handshake. The first post-reset cycle matches the reset values.
- `valid` at cycle t → `row_v` at t+COLS-1 → buffer write visible at t+COLS.
- First `out_valid` is 2 cycles after the last `row_v` cycle:
  - one cycle for the state change;
  - one cycle for the registered read.
- Throughput: one row per cycle in both ACCUM and DRAIN.
- `in_ready` goes low in the same cycle the state enters DRAIN. The upstream must not issue `valid` while it is low.

## Configuration
- `SUPER_SYS_DRAIN_SAT_EN` defined:
  - Accumulation saturates to +2^(ACC_W-1)-1 or -2^(ACC_W-1) on signed overflow.
  - Saturation does not set `err`.
- Undefined: accumulation wraps modulo 2^ACC_W.

## Test plan
- Single tile, first=last=1, 4 rows, row r lane c = r*16+c, skew honoured → 4 outputs equal to those values; `out_last` on row 3; first `out_valid` at t0+COLS+1.
- Two tiles of 3 rows, all lanes 5 then -2, second tile last=1 → 3 rows, every lane = 3.
- Backpressure: `out_ready` toggling 1,0,0,1 during a 4-row drain → rows appear in order, held stable while stalled, no duplicates.
- Overflow: DEPTH+1 rows in one tile → `err`=1; DEPTH rows drained.
- Saturation: lane 0 = 2^23-1 added across 300 tiles, with the macro defined → output is exactly 2^31-1.
  - With the macro undefined, the same stimulus gives the wrapped value.
- Reset low for 1 cycle mid-DRAIN → `out_valid`=0, `in_ready`=1 the next cycle; a following single tile drains correctly.

Source files
------------

// File: rtl/super_sys_drain_if.sv
`default_nettype none
// ============================================================================
// super_sys_drain_if : array-side row bus and writeback-side row handshake
// Rev 1.0
// ============================================================================
interface super_sys_drain_if #(
  parameter int COLS       = 16,
  parameter int P_BITWIDTH = 24,
  parameter int ACC_W      = 32
);
  logic [COLS-1:0][P_BITWIDTH-1:0] of_data;
  logic                            valid;
  logic                            accum_start;
  logic                            tile_first;
  logic                            tile_last;
  logic                            in_ready;
  logic [COLS-1:0][ACC_W-1:0]      out_data;
  logic                            out_valid;
  logic                            out_ready;
  logic                            out_last;

  modport master (
    output of_data, valid, accum_start, tile_first, tile_last, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  of_data, valid, accum_start, tile_first, tile_last, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface
`default_nettype wire

// File: rtl/super_sys_drain.sv
`default_nettype none
// ============================================================================
// super_sys_drain : de-skews systolic partial sums, accumulates K-tiles, drains rows
// Optional saturating accumulation: define SUPER_SYS_DRAIN_SAT_EN.  Rev 1.0
// ============================================================================
module super_sys_drain #(
  parameter int COLS       = 16,
  parameter int P_BITWIDTH = 24,
  parameter int ACC_W      = 32,
  parameter int DEPTH      = 16
) (
  input  logic             clk,
  input  logic             rst,
  super_sys_drain_if.slave bus,
  output logic             err
);
  localparam int c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                                r_state;
  logic [COLS-2:0]                       r_v_sr;
  logic [COLS-2:0][2:0]                  r_c_sr;
  logic                                  r_first;
  logic                                  r_last;
  logic [c_cnt_w-1:0]                    r_wr_row;
  logic [c_cnt_w-1:0]                    r_n_rows;
  logic [c_cnt_w-1:0]                    r_rd_row;
  logic [DEPTH-1:0][COLS-1:0][ACC_W-1:0] r_buf;
  logic [COLS-1:0][ACC_W-1:0]            r_out_data;
  logic                                  r_out_valid;
  logic                                  r_out_last;
  logic                                  r_err;

  logic                                  w_valid_in;
  logic [COLS-1:0]                       w_v_taps;
  logic [COLS-1:0][2:0]                  w_c_taps;
  logic                                  w_row_v;
  logic                                  w_row_v_next;
  logic                                  w_row_start;
  logic                                  w_row_first;
  logic                                  w_row_last;
  logic [COLS-1:0][P_BITWIDTH-1:0]       w_row;
  logic [COLS-1:0][ACC_W-1:0]            w_new;
  logic [c_idx_w-1:0]                    w_wr_idx;
  logic [c_idx_w-1:0]                    w_rd_idx;
  logic [c_cnt_w-1:0]                    w_rd_next;
  logic [c_idx_w-1:0]                    w_rd_next_idx;
  logic [c_cnt_w-1:0]                    w_last_row;

  // Rows arriving while draining are discarded before they enter the de-skew pipe.
  assign w_valid_in   = bus.valid && (r_state != S_DRAIN);
  assign w_v_taps     = {r_v_sr, w_valid_in};
  assign w_c_taps     = {r_c_sr, {bus.accum_start, bus.tile_first, bus.tile_last}};
  assign w_row_v      = w_v_taps[COLS-1];
  assign w_row_v_next = w_v_taps[COLS-2];
  assign w_row_start  = w_c_taps[COLS-1][2];
  assign w_row_first  = w_c_taps[COLS-1][1];
  assign w_row_last   = w_c_taps[COLS-1][0];

  assign w_wr_idx      = r_wr_row[c_idx_w-1:0];
  assign w_rd_idx      = r_rd_row[c_idx_w-1:0];
  assign w_rd_next     = r_rd_row + 1'b1;
  assign w_rd_next_idx = w_rd_next[c_idx_w-1:0];
  assign w_last_row    = r_n_rows - 1'b1;

  for (genvar c = 0; c < COLS; c++) begin : g_lane
    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] w_old;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_acc;

    if (c == COLS - 1) begin : g_pass
      assign w_row[c] = bus.of_data[c];
    end else begin : g_dly
      logic [COLS-2-c:0][P_BITWIDTH-1:0] r_sr;
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_sr <= '0;
        end else begin
          r_sr[0] <= bus.of_data[c];
          for (int k = 1; k < COLS - 1 - c; k++) begin
            r_sr[k] <= r_sr[k-1];
          end
        end
      end
      assign w_row[c] = r_sr[COLS-2-c];
    end

    assign w_ext = ACC_W'($signed(w_row[c]));
    assign w_old = r_buf[w_wr_idx][c];
    assign w_sum = w_old + w_ext;
`ifdef SUPER_SYS_DRAIN_SAT_EN
    logic w_ovf;
    // Signed overflow only when both addends share a sign the sum does not.
    assign w_ovf = (w_old[ACC_W-1] == w_ext[ACC_W-1]) && (w_sum[ACC_W-1] != w_old[ACC_W-1]);
    assign w_acc = !w_ovf         ? w_sum :
                   w_old[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                    {1'b0, {(ACC_W-1){1'b1}}};
`else
    assign w_acc = w_sum;
`endif
    assign w_new[c] = r_first ? w_ext : w_acc;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_v_sr      <= '0;
      r_c_sr      <= '0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
      r_wr_row    <= '0;
      r_n_rows    <= '0;
      r_rd_row    <= '0;
      r_buf       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_v_sr <= w_v_taps[COLS-2:0];
      r_c_sr <= w_c_taps[COLS-2:0];
      if (bus.valid && (r_state == S_DRAIN)) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_row_start) begin
            r_state  <= S_ACCUM;
            r_first  <= w_row_first;
            r_last   <= w_row_last;
            r_wr_row <= '0;
          end
        end
        S_ACCUM: begin
          if (w_row_v) begin
            if (r_wr_row == c_depth) begin
              r_err <= 1'b1;
            end else begin
              r_buf[w_wr_idx] <= w_new;
              r_wr_row        <= r_wr_row + 1'b1;
              if (r_wr_row >= r_n_rows) begin
                r_n_rows <= r_wr_row + 1'b1;
              end
            end
            // Look one stage up the pipe so the tile end is acted on in the last row cycle.
            if (!w_row_v_next && !w_row_start) begin
              r_state  <= r_last ? S_DRAIN : S_IDLE;
              r_rd_row <= '0;
            end
          end
          if (w_row_start) begin
            r_first  <= w_row_first;
            r_last   <= w_row_last;
            r_wr_row <= '0;
          end
        end
        S_DRAIN: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_buf[w_rd_idx];
            r_out_last  <= (r_rd_row == w_last_row);
          end else if (bus.out_ready) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_n_rows    <= '0;
              r_state     <= S_IDLE;
            end else begin
              r_rd_row   <= w_rd_next;
              r_out_data <= r_buf[w_rd_next_idx];
              r_out_last <= (w_rd_next == w_last_row);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state != S_DRAIN);
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign err           = r_err;
endmodule
`default_nettype wire

// File: tb/tb_super_sys_drain.sv
`default_nettype none
// ============================================================================
// tb_super_sys_drain : vector table plus scoreboard bench for super_sys_drain
// Rev 1.0
// ============================================================================
module tb_super_sys_drain;
  localparam int COLS  = 16;
  localparam int PW    = 24;
  localparam int AW    = 32;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  logic err;

  super_sys_drain_if #(.COLS(COLS), .P_BITWIDTH(PW), .ACC_W(AW)) bus ();

  super_sys_drain #(.COLS(COLS), .P_BITWIDTH(PW), .ACC_W(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .err (err)
  );

  always #5 clk = ~clk;

  typedef logic [COLS-1:0][AW-1:0] row_t;
  typedef struct {
    row_t data;
    logic last;
  } exp_t;
  typedef struct {
    int   rows;
    int   tiles;
    int   pat;
    int   rmode;
    logic exp_err;
    int   exp_nout;
  } vec_t;

  exp_t   sb[$];
  vec_t   vecs[6];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     n_out = 0;
  int     first_v_cyc = -1;
  int     t_last = 0;
  int     rmode = 0;
  int     ridx = 0;
  int     m_nrows = 0;
  longint m_acc[DEPTH][COLS];
  logic signed [PW-1:0] tv[DEPTH+4][COLS];

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready pattern driver: 0 = always, 1 = 1,0,0,1 repeating, else held low
  initial forever begin
    @(posedge clk);
    #1;
    case (rmode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ((ridx % 4) == 0) || ((ridx % 4) == 3);
      default: bus.out_ready = 1'b0;
    endcase
    ridx = ridx + 1;
  end

  // Output monitor: every presented row must equal the oldest outstanding row.
  initial forever begin
    @(negedge clk);
    if (rst === 1'b1 && bus.out_valid === 1'b1) begin
      if (first_v_cyc < 0) first_v_cyc = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got row %h with nothing outstanding", bus.out_data);
      end else begin
        if (bus.out_data !== sb[0].data || bus.out_last !== sb[0].last) begin
          errors++;
          $display("FAIL out_row: got data %h last %0b, exp data %h last %0b",
                   bus.out_data, bus.out_last, sb[0].data, sb[0].last);
        end
        if (bus.out_ready === 1'b1) void'(sb.pop_front());
      end
      if (bus.out_ready === 1'b1) n_out++;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d exp %0d", name, $signed(got), $signed(exp));
    end
  endtask

  function automatic logic signed [PW-1:0] gen_val(int pat, int tile, int r, int c);
    case (pat)
      0:       return PW'(r * 16 + c);
      1:       return (tile == 0) ? PW'(5) : PW'(-2);
      2:       return (c == 0) ? PW'(24'h7FFFFF) : PW'(0);
      default: return PW'($urandom);
    endcase
  endfunction

  function automatic longint acc_add(longint a, longint b);
    longint s;
    s = a + b;
`ifdef SUPER_SYS_DRAIN_SAT_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    else if (s < -64'sd2147483648) s = -64'sd2147483648;
`else
    s = longint'(int'(s));
`endif
    return s;
  endfunction

  task automatic idle_inputs();
    bus.valid       = 1'b0;
    bus.accum_start = 1'b0;
    bus.tile_first  = 1'b0;
    bus.tile_last   = 1'b0;
    bus.of_data     = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    m_nrows = 0;
    for (int r = 0; r < DEPTH; r++)
      for (int c = 0; c < COLS; c++) m_acc[r][c] = 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_out_last"},  64'(bus.out_last),  64'd0);
    chk({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
    chk({tag, "_err"},       64'(err),           64'd0);
    chk({tag, "_out_data"},  64'(|bus.out_data), 64'd0);
  endtask

  // One tile: accum_start, then rows on valid with lane c delayed by c cycles.
  task automatic drive_tile(input int tile, input int rows, input int pat, input bit first, input bit last);
    int keep;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < COLS; c++) begin
        tv[r][c] = gen_val(pat, tile, r, c);
        if (r < DEPTH)
          m_acc[r][c] = first ? longint'(tv[r][c]) : acc_add(m_acc[r][c], longint'(tv[r][c]));
      end
    end
    keep = (rows > DEPTH) ? DEPTH : rows;
    if (keep > m_nrows) m_nrows = keep;
    if (last) begin
      for (int r = 0; r < m_nrows; r++) begin
        exp_t e;
        for (int c = 0; c < COLS; c++) e.data[c] = AW'(m_acc[r][c]);
        e.last = (r == m_nrows - 1);
        sb.push_back(e);
      end
    end
    for (int k = 0; k < rows + COLS; k++) begin
      @(posedge clk);
      #1;
      bus.accum_start = (k == 0);
      bus.tile_first  = (k == 0) ? first : 1'($urandom_range(0, 1));
      bus.tile_last   = (k == 0) ? last  : 1'($urandom_range(0, 1));
      bus.valid       = (k >= 1) && (k <= rows);
      for (int c = 0; c < COLS; c++) begin
        int r;
        r = k - 1 - c;
        bus.of_data[c] = (r >= 0 && r < rows) ? tv[r][c] : PW'($urandom);
      end
      if (k == rows) t_last = cyc;
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_drain_timeout: got %0d rows outstanding exp 0", tag, sb.size());
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{rows: 4,         tiles: 1,   pat: 0, rmode: 0, exp_err: 1'b0, exp_nout: 4};
    vecs[1] = '{rows: 3,         tiles: 2,   pat: 1, rmode: 0, exp_err: 1'b0, exp_nout: 3};
    vecs[2] = '{rows: 4,         tiles: 1,   pat: 3, rmode: 1, exp_err: 1'b0, exp_nout: 4};
    vecs[3] = '{rows: DEPTH + 1, tiles: 1,   pat: 0, rmode: 0, exp_err: 1'b1, exp_nout: DEPTH};
    vecs[4] = '{rows: 2,         tiles: 300, pat: 2, rmode: 0, exp_err: 1'b0, exp_nout: 2};
    vecs[5] = '{rows: 5,         tiles: 3,   pat: 3, rmode: 1, exp_err: 1'b0, exp_nout: 5};

    rst = 1'b0;
    bus.out_ready = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    check_reset_values("por");

    for (int i = 0; i < 6; i++) begin
      do_reset();
      rmode = vecs[i].rmode;
      ridx = 0;
      n_out = 0;
      first_v_cyc = -1;
      for (int t = 0; t < vecs[i].tiles; t++)
        drive_tile(t, vecs[i].rows, vecs[i].pat, t == 0, t == vecs[i].tiles - 1);
      wait_drain($sformatf("v%0d", i));
      chk($sformatf("v%0d_rows_out", i), 64'(n_out), 64'(vecs[i].exp_nout));
      chk($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d_first_valid_cycle", i), 64'(first_v_cyc), 64'(t_last + COLS + 1));
    end

    // Stall in DRAIN, poke valid (error), then reset mid-drain and recover.
    do_reset();
    rmode = 2;
    n_out = 0;
    first_v_cyc = -1;
    drive_tile(0, 3, 0, 1'b1, 1'b1);
    for (int n = 0; n < 100 && bus.out_valid !== 1'b1; n++) begin
      @(posedge clk);
      #1;
    end
    chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    chk("stall_err_clear", 64'(err), 64'd0);
    @(posedge clk);
    #1;
    bus.valid = 1'b1;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    chk("drain_valid_err", 64'(err), 64'd1);
    chk("stall_no_handshake", 64'(n_out), 64'd0);
    do_reset();
    check_reset_values("mid_drain_reset");
    rmode = 0;
    n_out = 0;
    first_v_cyc = -1;
    drive_tile(0, 2, 3, 1'b1, 1'b1);
    wait_drain("post_reset");
    chk("post_reset_rows_out", 64'(n_out), 64'd2);
    chk("post_reset_first_valid_cycle", 64'(first_v_cyc), 64'(t_last + COLS + 1));
    chk("post_reset_err", 64'(err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
